// File: rtl/mul.sv
// Signed fixed-point multiplier, Q(WIDTH-FBITS).FBITS operands and result.
// Sequential shift-add on magnitudes: one result every WIDTH+2 cycles, with overflow detection.
module mul #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic                    ovf,
    output logic signed [WIDTH-1:0] val
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    // Largest representable magnitudes: 2^(WIDTH-1) for negative results, one less for positive.
    localparam logic [2*WIDTH-1:0] NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] POS_LIM = NEG_LIM - 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t state_reg, state_next;

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic               sign_reg;
    logic [CW-1:0]      cnt_reg;

    logic               busy_reg;
    logic               done_reg;
    logic               valid_reg;
    logic               ovf_reg;
    logic [WIDTH-1:0]   val_reg;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] m_full;
    logic [WIDTH-1:0]   m_low;
    logic               ovf_next;
    logic [WIDTH-1:0]   val_next;

    // Negating the most negative operand wraps to 2^(WIDTH-1), which is exact as unsigned.
    assign abs_a = a[WIDTH-1] ? $unsigned(-a) : $unsigned(a);
    assign abs_b = b[WIDTH-1] ? $unsigned(-b) : $unsigned(b);

    assign m_full   = acc_reg >> FBITS;
    assign m_low    = m_full[WIDTH-1:0];
    assign ovf_next = sign_reg ? (m_full > NEG_LIM) : (m_full > POS_LIM);
    assign val_next = ovf_next ? '0 : (sign_reg ? (~m_low + 1'b1) : m_low);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt_reg == LAST_STEP) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            sign_reg   <= 1'b0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            val_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg  <= {{WIDTH{1'b0}}, abs_a};
                        mplier_reg <= abs_b;
                        sign_reg   <= a[WIDTH-1] ^ b[WIDTH-1];
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                    end
                end
                CALC: begin
                    if (mplier_reg[0]) begin
                        acc_reg <= acc_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                end
                FIN: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    ovf_reg   <= ovf_next;
                    valid_reg <= ~ovf_next;
                    val_reg   <= val_next;
                end
                default: ;
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign valid = valid_reg;
    assign ovf   = ovf_reg;
    assign val   = $signed(val_reg);

endmodule

// File: tb/tb_mul.sv
// Directed-vector bench for the Q16.16 sequential multiplier: table of products plus
// hand sequences for back-to-back starts, ignored starts and mid-operation reset.
module tb_mul;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic               busy;
    logic               done;
    logic               valid;
    logic               ovf;
    logic signed [31:0] val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] val;
        logic        valid;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    mul #(.WIDTH(32), .FBITS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .ovf   (ovf),
        .val   (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // One start pulse, then wait (bounded) for done and compare the registered results.
    task automatic run_mul(input logic [31:0] ia, input logic [31:0] ib,
                           input logic [31:0] ev, input logic evalid, input logic eovf);
        int  bc;
        bit  seen;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(bc), 32'd33);
        chk("val", val, ev);
        chk("valid", 32'(valid), 32'(evalid));
        chk("ovf", 32'(ovf), 32'(eovf));
        $display("mul a=%h b=%h -> val=%h valid=%0d ovf=%0d busy_cycles=%0d", ia, ib, val, valid, ovf, bc);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int last_done;
        int pulses;
        bit seen;

        vecs[0]  = '{32'h00018000, 32'h00020000, 32'h00030000, 1'b1, 1'b0}; // 1.5*2
        vecs[1]  = '{32'hFFFE8000, 32'h00020000, 32'hFFFD0000, 1'b1, 1'b0}; // -1.5*2
        vecs[2]  = '{32'h00000001, 32'h00008000, 32'h00000000, 1'b1, 1'b0}; // underflows to 0
        vecs[3]  = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b1, 1'b0}; // most negative * 1
        vecs[4]  = '{32'h7FFF0000, 32'h00020000, 32'h00000000, 1'b0, 1'b1}; // positive overflow
        vecs[5]  = '{32'hFFFF0000, 32'hFFFF0000, 32'h00010000, 1'b1, 1'b0}; // -1*-1
        vecs[6]  = '{32'hFFFFFFFF, 32'h00008000, 32'h00000000, 1'b1, 1'b0}; // negative zero
        vecs[7]  = '{32'hFFFE8000, 32'h00008000, 32'hFFFF4000, 1'b1, 1'b0}; // -1.5*0.5
        vecs[8]  = '{32'h00000003, 32'h00008000, 32'h00000001, 1'b1, 1'b0}; // truncation
        vecs[9]  = '{32'hFFFFFFFD, 32'h00008000, 32'hFFFFFFFF, 1'b1, 1'b0}; // toward zero
        vecs[10] = '{32'h80000000, 32'hFFFF0000, 32'h00000000, 1'b0, 1'b1}; // -min * -1
        vecs[11] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1}; // min*min
        vecs[12] = '{32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b1, 1'b0}; // max * 1
        vecs[13] = '{32'h00000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0}; // 0 * min
        vecs[14] = '{32'h00800000, 32'hFF000000, 32'h80000000, 1'b1, 1'b0}; // 128*-256 limit
        vecs[15] = '{32'h00800000, 32'h01000000, 32'h00000000, 1'b0, 1'b1}; // 128*256 overflow

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_val", val, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].val, vecs[i].valid, vecs[i].ovf);
        end

        // Operand and start changes during CALC must be ignored.
        @(negedge clk);
        a = 32'h00018000; b = 32'h00020000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 32'h7FFFFFFF; b = 32'h80000000; start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("midcalc_done", 32'(seen), 32'd1);
        chk("midcalc_val", val, 32'h00030000);
        $display("midcalc start/operand change -> val=%h", val);
        @(negedge clk);
        chk("midcalc_idle", 32'(busy), 32'd0);

        // Start held high: a done pulse every 34 cycles.
        @(negedge clk);
        a = 32'h00010000; b = 32'h00010000; start = 1'b1;
        pulses = 0; last_done = -1;
        for (int i = 0; i < 400 && pulses < 3; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                chk("stream_val", val, 32'h00010000);
                if (last_done >= 0) chk("stream_interval", 32'(i - last_done), 32'd34);
                $display("stream pulse %0d at cycle %0d val=%h", pulses, i, val);
                last_done = i;
            end
        end
        start = 1'b0;
        chk("stream_pulses", 32'(pulses), 32'd3);
        @(negedge clk);
        chk("stream_stop", 32'(busy), 32'd0);

        // Reset in the middle of CALC, with start asserted during reset.
        @(negedge clk);
        a = 32'h00018000; b = 32'h00020000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_val", val, 32'd0);
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        $display("reset abort -> busy=%0d valid=%0d val=%h", busy, valid, val);
        run_mul(32'h00018000, 32'h00020000, 32'h00030000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul.md
MUL -- requirements
Module: mul

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning total operand/result width in bits.
REQ-002 SHALL have parameter FBITS, default 16, meaning fractional bits of operands and result (signed Q(WIDTH-FBITS).FBITS).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request to begin a multiply, sampled only in IDLE.
REQ-006 SHALL have port a  input  WIDTH signed  multiplicand, latched on accepted start.
REQ-007 SHALL have port b  input  WIDTH signed  multiplier, latched on accepted start.
REQ-008 SHALL have port busy  output  1  operation in progress (CALC or FIN).
REQ-009 SHALL have port done  output  1  single-cycle pulse, result registers updated.
REQ-010 SHALL have port valid  output  1  val holds a correct in-range product.
REQ-011 SHALL have port ovf  output  1  product magnitude not representable in WIDTH bits.
REQ-012 SHALL have port val  output  WIDTH signed  product a*b in same Q format as inputs.

Function
REQ-013 SHALL implement states IDLE, CALC, FIN; all outputs registered.
REQ-014 Edge E0, IDLE with start=1: latch |a|, |b| as WIDTH-bit unsigned magnitudes, latch sign=a[MSB]^b[MSB], clear 2*WIDTH-bit accumulator, clear iteration counter, busy<=1, done<=0, state<=CALC.
REQ-015 start while busy=1 (CALC or FIN) SHALL be ignored with no effect on operands or state.
REQ-016 CALC SHALL perform one shift-add step per cycle (LSB of multiplier conditionally adds shifted multiplicand), exactly WIDTH steps on edges E1..E(WIDTH), then state<=FIN.
REQ-017 FIN at edge E(WIDTH+1): magnitude m = accumulator >> FBITS (truncation of magnitude, i.e. round toward zero after sign applied); busy<=0, done<=1, state<=IDLE.
REQ-018 Overflow rule: ovf=1 if sign=0 and m > 2^(WIDTH-1)-1, or sign=1 and m > 2^(WIDTH-1); otherwise ovf=0.
REQ-019 On ovf=1: val<=0, valid<=0. On ovf=0: val<= sign ? -m : m (two's complement, WIDTH bits), valid<=1.
REQ-020 Result m=0 with sign=1 SHALL yield val=0 (no negative zero concerns; valid=1).
REQ-021 done SHALL be high exactly one cycle; cleared at the next edge regardless of start.
REQ-022 Latency: done visible in cycle after edge E(WIDTH+1); earliest next accepted start at edge E(WIDTH+2); throughput one result per WIDTH+2 cycles.
REQ-023 val, valid, ovf SHALL hold their values from FIN until the next FIN; an accepted start SHALL not alter them.
REQ-024 Operand -2^(WIDTH-1) SHALL be handled exactly (magnitude 2^(WIDTH-1) fits unsigned WIDTH bits).

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, valid=0, ovf=0, val=0, internal operands/accumulator/counter=0.
REQ-026 Reset during CALC or FIN SHALL abort the operation; no done pulse follows; next start after rst_n=1 begins a fresh multiply.
REQ-027 start asserted while rst_n=0 SHALL be ignored; start sampled only on edges with rst_n=1.

Verification (WIDTH=32, FBITS=16)
REQ-028 a=0x00018000 (1.5), b=0x00020000 (2.0), start 1 cycle -> busy high 33 cycles, done pulse after edge E33, val=0x00030000, valid=1, ovf=0.
REQ-029 a=0xFFFE8000 (-1.5), b=0x00020000 -> val=0xFFFD0000, valid=1, ovf=0; a=0x00000001, b=0x00008000 -> val=0x00000000, valid=1.
REQ-030 a=0x80000000 (-32768.0), b=0x00010000 (1.0) -> val=0x80000000, valid=1, ovf=0; a=0x7FFF0000, b=0x00020000 -> ovf=1, valid=0, val=0.
REQ-031 start held high continuously with a=b=0x00010000 -> one done pulse every 34 cycles, val=0x00010000 each time; operand changes mid-CALC do not affect result.
REQ-032 rst_n pulsed low at E10 of a multiply -> busy=0, done=0, valid=0, val=0 immediately; no done pulse afterwards; subsequent start with 1.5*2.0 -> 0x00030000.
